vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator.
- Takes Sync_Horiz_In/Sync_Vert_In from a 640x480@60 stream clocked by the same 25 MHz pixel clock.
- Locks to the stream and regenerates column/row coordinates, display enable and a frame-start strobe.
- Used as an in-system checker of the sync generator and as the front end for a future frame-capture path; reports lock status and a sync-error count.

---
 rtl/vga_sync_decoder_pkg.sv | 36 +++
 rtl/vga_sync_decoder_edge_sync.sv | 28 ++
 rtl/vga_sync_decoder.sv | 168 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared 640x480@60 timing constants and decoder FSM encodings.
// Used by the sync generator and the sync decoder alike.
package vga_sync_decoder_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   localparam int VGA_H_TOTAL =
      VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
   localparam int VGA_V_TOTAL =
      VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;

   localparam int   VGA_LOCK_LINES = 4;
   localparam logic VGA_SYNC_POL   = 1'b0;

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_H_TRAIN = 2'd1;
   localparam logic [1:0] ST_H_LOCK  = 2'd2;
   localparam logic [1:0] ST_LOCKED  = 2'd3;

   function automatic logic [9:0] wrap_inc(
      input logic [9:0] v,
      input logic [9:0] last
   );
      return (v == last) ? 10'd0 : v + 10'd1;
   endfunction

endpackage

// File: rtl/vga_sync_decoder_edge_sync.sv
// Sync input register plus active-edge detector.
// Edge is flagged the cycle after the active level is first registered.
module vga_edge_sync #(
   parameter logic SYNC_POL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sync_i,
   output logic edge_o
);

   logic sync_q;
   logic prev_q;

   // Reset to the idle level so an already-active input is not an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= ~SYNC_POL;
         prev_q <= ~SYNC_POL;
      end else begin
         sync_q <= sync_i;
         prev_q <= sync_q;
      end
   end

   assign edge_o = (sync_q == SYNC_POL) && (prev_q != SYNC_POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers VGA raster position from incoming hsync/vsync.
// Outputs are registered from next-state values to keep fixed latency.
module vga_sync_decoder
   import vga_sync_decoder_pkg::*;
#(
   parameter int   H_VISIBLE  = VGA_H_VISIBLE,
   parameter int   H_FP       = VGA_H_FP,
   parameter int   H_SYNC     = VGA_H_SYNC,
   parameter int   H_BP       = VGA_H_BP,
   parameter int   V_VISIBLE  = VGA_V_VISIBLE,
   parameter int   V_FP       = VGA_V_FP,
   parameter int   V_SYNC     = VGA_V_SYNC,
   parameter int   V_BP       = VGA_V_BP,
   parameter int   LOCK_LINES = VGA_LOCK_LINES,
   parameter logic SYNC_POL   = VGA_SYNC_POL
) (
   input  logic       Master_Clock_In,
   input  logic       Reset_In,
   input  logic       Sync_Horiz_In,
   input  logic       Sync_Vert_In,
   output logic [9:0] Val_Col_Out,
   output logic [9:0] Val_Row_Out,
   output logic       Disp_Ena_Out,
   output logic       Frame_Start_Out,
   output logic       Locked_Out,
   output logic [7:0] Sync_Err_Count_Out
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
   localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
   localparam logic [9:0] HSS   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] VSS   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] HV    = 10'(H_VISIBLE);
   localparam logic [9:0] VV    = 10'(V_VISIBLE);
   localparam logic [7:0] LL_M1 = 8'(LOCK_LINES - 1);

   logic h_edge;
   logic v_edge;

   vga_edge_sync #(.SYNC_POL(SYNC_POL)) u_hsync (
      .clk_i  (Master_Clock_In),
      .rst_i  (Reset_In),
      .sync_i (Sync_Horiz_In),
      .edge_o (h_edge)
   );

   vga_edge_sync #(.SYNC_POL(SYNC_POL)) u_vsync (
      .clk_i  (Master_Clock_In),
      .rst_i  (Reset_In),
      .sync_i (Sync_Vert_In),
      .edge_o (v_edge)
   );

   logic [1:0] state_q, state_d;
   logic [9:0] hp_q, hp_d;
   logic [9:0] vp_q, vp_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pend_q, pend_d;
   logic [7:0] err_q, err_d;
   logic [9:0] col_q, col_d;
   logic [9:0] row_q, row_d;
   logic       de_q, de_d;
   logic       fs_q, fs_d;
   logic       lock_q, lock_d;

   logic [9:0] hp_nxt;
   logic       consume;
   logic       h_err;
   logic       v_err;

   always_comb begin
      hp_nxt  = wrap_inc(hp_q, HT_M1);
      consume = h_edge && (pend_q || v_edge);
      pend_d  = consume ? 1'b0 : (pend_q || v_edge);
      h_err   = (state_q != ST_SEARCH)
             && (h_edge != (hp_nxt == HSS));
      v_err   = (state_q == ST_LOCKED) && consume
             && (vp_q != VSS);

      hp_d    = h_edge ? HSS : hp_nxt;
      vp_d    = (hp_q == HT_M1 && !h_edge)
              ? wrap_inc(vp_q, VT_M1) : vp_q;
      cnt_d   = cnt_q;
      state_d = state_q;

      unique case (state_q)
         ST_SEARCH: begin
            if (h_edge) begin
               cnt_d   = '0;
               state_d = ST_H_TRAIN;
            end
         end
         ST_H_TRAIN: begin
            if (h_err) begin
               cnt_d = '0;
            end else if (h_edge) begin
               if (cnt_q == LL_M1) begin
                  cnt_d   = '0;
                  state_d = ST_H_LOCK;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_H_LOCK: begin
            if (h_err) begin
               state_d = ST_SEARCH;
            end else if (consume) begin
               vp_d    = VSS;
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (h_err || v_err) state_d = ST_SEARCH;
         end
         default: state_d = ST_SEARCH;
      endcase

      // Coincident H and V mismatches are one event.
      err_d = ((h_err || v_err) && err_q != 8'hFF)
            ? err_q + 8'd1 : err_q;

      lock_d = (state_d == ST_LOCKED);
      col_d  = lock_d ? hp_d : 10'd0;
      row_d  = lock_d ? vp_d : 10'd0;
      de_d   = lock_d && (hp_d < HV) && (vp_d < VV);
      fs_d   = lock_d && (hp_d == 10'd0) && (vp_d == 10'd0);
   end

   always_ff @(posedge Master_Clock_In) begin
      if (Reset_In) begin
         state_q <= ST_SEARCH;
         hp_q    <= '0;
         vp_q    <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         vp_q    <= vp_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         col_q   <= col_d;
         row_q   <= row_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         lock_q  <= lock_d;
      end
   end

   assign Val_Col_Out        = col_q;
   assign Val_Row_Out        = row_q;
   assign Disp_Ena_Out       = de_q;
   assign Frame_Start_Out    = fs_q;
   assign Locked_Out         = lock_q;
   assign Sync_Err_Count_Out = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced raster.
// A generator drives syncs; expectations are queued with their due cycle.
module tb_vga_sync_decoder;

   localparam int HV = 16, HF = 4, HS = 6, HB = 6;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int HSS = HV + HF;
   localparam int VSS = VV + VF;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs  = 1'b1;
   logic       vs  = 1'b1;
   logic [9:0] col, row;
   logic       de, fs, lock;
   logic [7:0] errc;

   always #20 clk = ~clk;

   vga_sync_decoder #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .LOCK_LINES(4), .SYNC_POL(1'b0)
   ) dut (
      .Master_Clock_In    (clk),
      .Reset_In           (rst),
      .Sync_Horiz_In      (hs),
      .Sync_Vert_In       (vs),
      .Val_Col_Out        (col),
      .Val_Row_Out        (row),
      .Disp_Ena_Out       (de),
      .Frame_Start_Out    (fs),
      .Locked_Out         (lock),
      .Sync_Err_Count_Out (errc)
   );

   typedef enum int {F_COL, F_ROW, F_DE, F_FS, F_LOCK, F_ERR, F_ALL} fld_t;
   typedef struct {
      int          due;
      fld_t        f;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   fs_times[$];
   int   n = 0, vectors = 0, miscompares = 0;
   int   gh = 0, gv = 0, vline = VSS, short_lines = 0;
   bit   track = 1'b0;
   int   hs_edge_n = -1, hs_edge_row = -1;

   function automatic logic [31:0] obs(fld_t f);
      case (f)
         F_COL:  return {22'd0, col};
         F_ROW:  return {22'd0, row};
         F_DE:   return {31'd0, de};
         F_FS:   return {31'd0, fs};
         F_LOCK: return {31'd0, lock};
         F_ERR:  return {24'd0, errc};
         default: return {1'b0, col, row, de, fs, lock, errc};
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)",
                tag, got, exp, n);
      end
   endtask

   task automatic expect_at(int due, fld_t f, logic [31:0] exp, string tag);
      exp_t e;
      e.due = due; e.f = f; e.exp = exp; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic cyc();
      exp_t keep[$];
      logic hs_n;
      @(negedge clk);
      n++;
      if (fs === 1'b1) fs_times.push_back(n);
      foreach (sb[i]) begin
         if (sb[i].due == n) check(sb[i].tag, obs(sb[i].f), sb[i].exp);
         else keep.push_back(sb[i]);
      end
      sb = keep;
      hs_n = (gh >= HSS && gh < HSS + HS) ? 1'b0 : 1'b1;
      if (hs && !hs_n) begin
         hs_edge_n   = n;
         hs_edge_row = gv;
      end
      hs = hs_n;
      vs = (gv >= vline && gv < vline + VS) ? 1'b0 : 1'b1;
      // Decoder position trails the generator by two cycles.
      if (track) begin
         expect_at(n + 2, F_COL, 32'(gh), "col");
         expect_at(n + 2, F_ROW, 32'(gv), "row");
         expect_at(n + 2, F_DE, 32'(gh < HV && gv < VV), "disp_ena");
         expect_at(n + 2, F_FS, 32'(gh == 0 && gv == 0), "frame_start");
         expect_at(n + 2, F_LOCK, 32'd1, "locked");
      end
      if (gh == ((short_lines > 0) ? HT - 2 : HT - 1)) begin
         gh = 0;
         gv = (gv == VT - 1) ? 0 : gv + 1;
         if (short_lines > 0) short_lines--;
      end else begin
         gh++;
      end
   endtask

   task automatic wait_lock(string tag, int budget);
      int k = 0;
      while (lock !== 1'b1 && k < budget) begin
         cyc();
         k++;
      end
      check(tag, {31'd0, lock}, 32'd1);
   endtask

   task automatic track_frames(int frames);
      track = 1'b1;
      repeat (frames * FRAME) cyc();
      track = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic next_edge();
      int e0 = hs_edge_n;
      while (hs_edge_n == e0) cyc();
   endtask

   initial begin
      cyc();
      expect_at(n + 1, F_ALL, 32'd0, "reset_all");
      repeat (2) cyc();
      rst = 1'b0;

      wait_lock("lock_acquire", 3 * FRAME);
      check("lock_row", {22'd0, row}, 32'(VSS));
      check("lock_col", {22'd0, col}, 32'(HSS));
      fs_times = {};
      track_frames(2);
      check("fs_count", 32'(fs_times.size()), 32'd2);
      if (fs_times.size() >= 2)
         check("fs_period", 32'(fs_times[1] - fs_times[0]), 32'(FRAME));
      check("err_clean", {24'd0, errc}, 32'd0);

      while (gh != 0) cyc();
      short_lines = 1;
      next_edge();
      next_edge();
      expect_at(n + 1, F_LOCK, 32'd1, "short_pre_lock");
      expect_at(n + 3, F_LOCK, 32'd0, "short_unlock");
      expect_at(n + 3, F_ERR, 32'd1, "short_err");
      repeat (4) cyc();
      wait_lock("short_relock", 3 * FRAME);
      check("short_err_hold", {24'd0, errc}, 32'd1);
      track_frames(1);

      while (!(gh == 0 && gv == 0)) cyc();
      vline = VSS + 1;
      do cyc(); while (!(hs_edge_n == n && hs_edge_row == VSS + 1));
      expect_at(n + 1, F_LOCK, 32'd1, "vdly_pre_lock");
      expect_at(n + 3, F_LOCK, 32'd0, "vdly_unlock");
      expect_at(n + 3, F_ERR, 32'd2, "vdly_err");
      while (!(gh == 0 && gv == 0)) cyc();
      vline = VSS;
      wait_lock("vdly_relock", 3 * FRAME);
      check("vdly_err_hold", {24'd0, errc}, 32'd2);
      track_frames(1);

      while (gh != 5) cyc();
      check("pre_reset_lock", {31'd0, lock}, 32'd1);
      rst = 1'b1;
      expect_at(n + 1, F_ALL, 32'd0, "midreset_all");
      cyc();
      rst = 1'b0;
      expect_at(n + 2, F_LOCK, 32'd0, "post_reset_search");
      cyc();
      wait_lock("reset_relock", 3 * FRAME);
      check("reset_err_zero", {24'd0, errc}, 32'd0);
      track_frames(1);

      while (gh != 0) cyc();
      short_lines = 300;
      while (short_lines > 200) cyc();
      next_edge();
      expect_at(n + 3, F_ERR, 32'd99, "glitch_err_99");
      while (short_lines > 0) cyc();
      repeat (2 * HT) cyc();
      check("err_saturated", {24'd0, errc}, 32'd255);
      check("glitch_unlocked", {31'd0, lock}, 32'd0);

      repeat (4) cyc();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
